// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one completing unit per cycle in round-robin
// order and broadcasts its tag/value on registered CDB outputs with a grant pulse.
module cdb_arbiter #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int NREQ   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*TAG_W-1:0]  req_tag,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic                   flush,
  output logic [NREQ-1:0]        gnt,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_id,
  output logic [DATA_W-1:0]      cdb_data,
  output logic [1:0]             cdb_src,
  output logic                   err_notag,
  output logic [15:0]            bcast_cnt
);

  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        src_q, src_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        ptr_q, ptr_d;

  logic [NREQ-1:0]   elig_s;
  logic              notag_s;
  logic              found_s;
  logic [1:0]        win_s;

  // Eligibility: the unit granted last edge is excluded so a result never goes out twice.
  always_comb begin
    elig_s  = '0;
    notag_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      elig_s[i] = req[i] & ~gnt_q[i] & (req_tag[i*TAG_W +: TAG_W] != '0);
      if (req[i] && (req_tag[i*TAG_W +: TAG_W] == '0)) begin
        notag_s = 1'b1;
      end else begin
        notag_s = notag_s;
      end
    end
  end

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    found_s = 1'b0;
    win_s   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found_s && elig_s[idx]) begin
        found_s = 1'b1;
        win_s   = 2'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state: broadcast the winner unless flushed; otherwise drive the idle pattern.
  always_comb begin
    gnt_d   = '0;
    valid_d = 1'b0;
    id_d    = '0;
    data_d  = '0;
    src_d   = 2'd0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q | notag_s;
    if (found_s && !flush) begin
      gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
      valid_d = 1'b1;
      id_d    = req_tag[int'(win_s)*TAG_W +: TAG_W];
      data_d  = req_data[int'(win_s)*DATA_W +: DATA_W];
      src_d   = win_s;
      cnt_d   = cnt_q + 16'd1;
      if (int'(win_s) == NREQ - 1) begin
        ptr_d = 2'd0;
      end else begin
        ptr_d = win_s + 2'd1;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; reset forces the bus idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      src_q   <= 2'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
      ptr_q   <= 2'd0;
    end else begin
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
      src_q   <= src_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign cdb_valid = valid_q;
  assign cdb_id    = id_q;
  assign cdb_data  = data_q;
  assign cdb_src   = src_q;
  assign err_notag = err_q;
  assign bcast_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes hand-computed expected bus
// state per edge, a monitor pops and compares after each rising edge.
module tb_cdb_arbiter;

  logic         clk;
  logic         rst_n;
  logic [2:0]   req;
  logic [11:0]  req_tag;
  logic [191:0] req_data;
  logic         flush;
  logic [2:0]   gnt;
  logic         cdb_valid;
  logic [3:0]   cdb_id;
  logic [63:0]  cdb_data;
  logic [1:0]   cdb_src;
  logic         err_notag;
  logic [15:0]  bcast_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        v;
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  src;
    logic [2:0]  g;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  cdb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_tag(req_tag), .req_data(req_data),
    .flush(flush), .gnt(gnt), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .err_notag(err_notag), .bcast_cnt(bcast_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and record the expected state after the next rising edge.
  task automatic step(input string nm, input logic [2:0] r, input logic [11:0] t,
                      input logic [191:0] d, input logic f, input logic ev,
                      input logic [3:0] eid, input logic [63:0] ed, input logic [1:0] es,
                      input logic [2:0] eg, input logic [15:0] ec, input logic ee);
    exp_t e;
    @(negedge clk);
    req = r; req_tag = t; req_data = d; flush = f;
    e = '{v: ev, id: eid, data: ed, src: es, g: eg, cnt: ec, err: ee};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm, input logic [15:0] ec, input logic ee);
    step(nm, 3'b000, 12'h000, 192'd0, 1'b0, 1'b0, 4'd0, 64'd0, 2'd0, 3'b000, ec, ee);
  endtask

  // Asynchronous reset mid-cycle; outputs must be idle before any clock edge.
  task automatic do_reset(input string nm);
    @(negedge clk);
    req = 3'b000; req_tag = 12'h000; req_data = 192'd0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_id !== 4'd0 || cdb_data !== 64'd0 || cdb_src !== 2'd0 ||
        gnt !== 3'b000 || bcast_cnt !== 16'd0 || err_notag !== 1'b0) begin
      errors++;
      $display("FAIL %s: got v=%0d id=%0d data=%0h src=%0d gnt=%b cnt=%0d err=%0d, want all zero",
               nm, cdb_valid, cdb_id, cdb_data, cdb_src, gnt, bcast_cnt, err_notag);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [191:0] dat(input logic [63:0] a, input logic [63:0] m, input logic [63:0] l);
    return {l, m, a};
  endfunction

  // Monitor: compare the presented bus state against the scoreboard after each rising edge.
  initial begin
    exp_t e;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (cdb_valid !== e.v || cdb_id !== e.id || cdb_data !== e.data || cdb_src !== e.src ||
            gnt !== e.g || bcast_cnt !== e.cnt || err_notag !== e.err) begin
          errors++;
          $display("FAIL %s: got v=%0d id=%0d data=%0h src=%0d gnt=%b cnt=%0d err=%0d, want v=%0d id=%0d data=%0h src=%0d gnt=%b cnt=%0d err=%0d",
                   nm, cdb_valid, cdb_id, cdb_data, cdb_src, gnt, bcast_cnt, err_notag,
                   e.v, e.id, e.data, e.src, e.g, e.cnt, e.err);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 3'b000; req_tag = 12'h000; req_data = 192'd0; flush = 1'b0;
    do_reset("reset_initial");

    for (int i = 0; i < 5; i++) idle("reset_idle", 16'd0, 1'b0);

    // Single adder request, then idle.
    step("single_add", 3'b001, 12'h001, dat(64'h55, 64'h0, 64'h0), 1'b0,
         1'b1, 4'd1, 64'h55, 2'd0, 3'b001, 16'd1, 1'b0);
    idle("single_idle", 16'd1, 1'b0);

    // Round-robin from ptr=0 with all three units continuously requesting.
    do_reset("reset_before_rr");
    step("rr0", 3'b111, 12'h641, dat(64'h1000, 64'h2000, 64'h3000), 1'b0, 1'b1, 4'd1, 64'h1000, 2'd0, 3'b001, 16'd1, 1'b0);
    step("rr1", 3'b111, 12'h641, dat(64'h1001, 64'h2001, 64'h3001), 1'b0, 1'b1, 4'd4, 64'h2001, 2'd1, 3'b010, 16'd2, 1'b0);
    step("rr2", 3'b111, 12'h641, dat(64'h1002, 64'h2002, 64'h3002), 1'b0, 1'b1, 4'd6, 64'h3002, 2'd2, 3'b100, 16'd3, 1'b0);
    step("rr3", 3'b111, 12'h641, dat(64'h1003, 64'h2003, 64'h3003), 1'b0, 1'b1, 4'd1, 64'h1003, 2'd0, 3'b001, 16'd4, 1'b0);
    step("rr4", 3'b111, 12'h641, dat(64'h1004, 64'h2004, 64'h3004), 1'b0, 1'b1, 4'd4, 64'h2004, 2'd1, 3'b010, 16'd5, 1'b0);
    step("rr5", 3'b111, 12'h641, dat(64'h1005, 64'h2005, 64'h3005), 1'b0, 1'b1, 4'd6, 64'h3005, 2'd2, 3'b100, 16'd6, 1'b0);
    idle("rr_idle", 16'd6, 1'b0);

    // Exclusion: multiplier holds req one cycle past its grant.
    step("excl_win",  3'b010, 12'h040, dat(64'h0, 64'hAB, 64'h0), 1'b0, 1'b1, 4'd4, 64'hAB, 2'd1, 3'b010, 16'd7, 1'b0);
    step("excl_hold", 3'b010, 12'h040, dat(64'h0, 64'hAB, 64'h0), 1'b0, 1'b0, 4'd0, 64'h0, 2'd0, 3'b000, 16'd7, 1'b0);
    idle("excl_idle", 16'd7, 1'b0);

    // A broadcast is on the bus when reset hits.
    step("pre_reset_bcast", 3'b001, 12'h001, dat(64'h77, 64'h0, 64'h0), 1'b0, 1'b1, 4'd1, 64'h77, 2'd0, 3'b001, 16'd8, 1'b0);
    do_reset("reset_mid_bcast");

    // Flush suppresses grant; adder then load win afterwards.
    step("flush",      3'b101, 12'h601, dat(64'hA0, 64'h0, 64'hC0), 1'b1, 1'b0, 4'd0, 64'h0, 2'd0, 3'b000, 16'd0, 1'b0);
    step("flush_add",  3'b101, 12'h601, dat(64'hA0, 64'h0, 64'hC0), 1'b0, 1'b1, 4'd1, 64'hA0, 2'd0, 3'b001, 16'd1, 1'b0);
    step("flush_load", 3'b100, 12'h600, dat(64'h0, 64'h0, 64'hC0),  1'b0, 1'b1, 4'd6, 64'hC0, 2'd2, 3'b100, 16'd2, 1'b0);
    idle("flush_idle", 16'd2, 1'b0);

    // Tag-0 request from load: never granted, error sticks.
    step("notag_add",  3'b101, 12'h001, dat(64'hE1, 64'h0, 64'hF0), 1'b0, 1'b1, 4'd1, 64'hE1, 2'd0, 3'b001, 16'd3, 1'b1);
    step("notag_only", 3'b101, 12'h001, dat(64'hE1, 64'h0, 64'hF0), 1'b0, 1'b0, 4'd0, 64'h0, 2'd0, 3'b000, 16'd3, 1'b1);
    step("notag_load", 3'b100, 12'h000, dat(64'h0, 64'h0, 64'hF0),  1'b0, 1'b0, 4'd0, 64'h0, 2'd0, 3'b000, 16'd3, 1'b1);
    idle("notag_sticky", 16'd3, 1'b1);
    idle("notag_sticky2", 16'd3, 1'b1);

    // Counter wrap: 65535 back-to-back broadcasts, then one more.
    do_reset("reset_before_wrap");
    @(negedge clk);
    req = 3'b011; req_tag = 12'h041; req_data = dat(64'h11, 64'h22, 64'h0); flush = 1'b0;
    repeat (65535) @(posedge clk);
    #2;
    checks++;
    if (bcast_cnt !== 16'hFFFF || cdb_src !== 2'd0) begin
      errors++;
      $display("FAIL wrap_preload: got cnt=%0h src=%0d, want cnt=ffff src=0", bcast_cnt, cdb_src);
    end
    step("wrap", 3'b011, 12'h041, dat(64'h11, 64'h22, 64'h0), 1'b0, 1'b1, 4'd4, 64'h22, 2'd1, 3'b010, 16'd0, 1'b0);
    idle("wrap_idle", 16'd0, 1'b0);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
